// File: rtl/io_pkg.sv
// Shared I/O-path types: FIFO entry layout, serializer state encoding and byte width.
// The machine word width comes from the `WORD_W macro and defaults to 32 here.
`ifndef WORD_W
`define WORD_W 32
`endif

package io_pkg;

  localparam int OUT_BYTE_W = 8;

  typedef struct packed {
    logic [1:0]  nbytes;
    logic [31:0] data;
  } out_entry_t;

  localparam int OUT_ENTRY_W = $bits(out_entry_t);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_GUARD,
    S_DRAIN
  } ser_state_t;

endpackage

// File: rtl/out_byte_serializer_if.sv
// Core push side and I/O-controller output handshake of the byte serializer.
// master = core/controller environment, slave = serializer.
`ifndef WORD_W
`define WORD_W 32
`endif

interface out_byte_serializer_if;

  logic               push_valid;
  logic [`WORD_W-1:0] push_data;
  logic [1:0]         push_nbytes;
  logic               push_ready;
  logic               out_req;
  logic [`WORD_W-1:0] out_data;
  logic               out_busy;

  modport master (
    output push_valid, push_data, push_nbytes, out_busy,
    input  push_ready, out_req, out_data
  );

  modport slave (
    input  push_valid, push_data, push_nbytes, out_busy,
    output push_ready, out_req, out_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, show-ahead read data and occupancy count.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/out_byte_serializer.sv
// Buffers core output words and issues one I/O-controller request per byte, LSB first.
// Optional macro OUT_TX_COUNT_EN adds a free-running count of issued bytes (tx_byte_count).
`ifndef WORD_W
`define WORD_W 32
`endif

module out_byte_serializer
  import io_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  out_byte_serializer_if.slave  bus,
  output logic [PTR_W:0]        fifo_count,
  output logic                  idle
`ifdef OUT_TX_COUNT_EN
  ,
  output logic [31:0]           tx_byte_count
`endif
);

  ser_state_t         state_q;
  logic [31:0]        shreg_q;
  logic [1:0]         rem_q;
  logic               out_req_q;
  logic [`WORD_W-1:0] out_data_q;

  out_entry_t push_entry;
  out_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  assign push_entry = '{nbytes: bus.push_nbytes, data: bus.push_data};
  assign pop        = (state_q == S_IDLE) && !fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.push_valid),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.push_ready = !fifo_full;
  assign bus.out_req    = out_req_q;
  assign bus.out_data   = out_data_q;
  assign idle           = fifo_empty && (state_q == S_IDLE);

  // S_GUARD masks the controller's one-cycle delay between sampling out_req and raising busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      rem_q      <= '0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            shreg_q <= head.data;
            rem_q   <= head.nbytes;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          out_data_q <= {{(`WORD_W-OUT_BYTE_W){1'b0}}, shreg_q[OUT_BYTE_W-1:0]};
          out_req_q  <= 1'b1;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          out_req_q <= 1'b0;
          state_q   <= S_GUARD;
        end
        S_GUARD: state_q <= S_DRAIN;
        S_DRAIN: begin
          if (!bus.out_busy) begin
            if (rem_q == 2'd0) begin
              state_q <= S_IDLE;
            end else begin
              shreg_q <= shreg_q >> OUT_BYTE_W;
              rem_q   <= rem_q - 2'd1;
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef OUT_TX_COUNT_EN
  logic [31:0] tx_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      tx_cnt_q <= tx_cnt_q + 32'd1;
    end
  end

  assign tx_byte_count = tx_cnt_q;
`endif

endmodule

// File: tb/tb_out_byte_serializer.sv
// Directed bench for out_byte_serializer with a busy-handshake controller model and byte capture.
`timescale 1ns/1ps
`ifndef WORD_W
`define WORD_W 32
`endif

module tb_out_byte_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  out_byte_serializer_if bus ();
  logic [4:0] fifo_count;
  logic       idle;
`ifdef OUT_TX_COUNT_EN
  logic [31:0] tx_byte_count;
`endif

  out_byte_serializer #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .idle       (idle)
`ifdef OUT_TX_COUNT_EN
    ,
    .tx_byte_count (tx_byte_count)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Controller model: busy rises the cycle after out_req is sampled, for busy_len cycles.
  int         cyc = 0;
  int         busy_len = 5;
  int         busy_left = 0;
  logic       busy_stuck = 1'b0;
  logic       prev_req = 1'b0;
  int         dbl_err = 0;
  int         hi_err = 0;
  int         last_push_cyc = 0;
  logic [7:0] got_q[$];
  int         req_cyc_q[$];
  logic [7:0] exp_q[$];

  assign bus.out_busy = busy_stuck | (busy_left != 0);

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_req <= bus.out_req;
    if (bus.out_req) begin
      got_q.push_back(bus.out_data[7:0]);
      req_cyc_q.push_back(cyc);
      if (bus.out_data[31:8] != 24'd0) hi_err <= hi_err + 1;
      if (prev_req) dbl_err <= dbl_err + 1;
      busy_left <= busy_len;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
    end
    if (bus.push_valid && bus.push_ready) last_push_cyc <= cyc;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    got_q.delete();
    req_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic add_exp(input logic [31:0] data, input logic [1:0] nb);
    for (int k = 0; k <= int'(nb); k++) exp_q.push_back(data[8*k +: 8]);
  endtask

  task automatic try_push(input logic [31:0] data, input logic [1:0] nb, output bit acc);
    @(negedge clk);
    bus.push_valid  = 1'b1;
    bus.push_data   = data;
    bus.push_nbytes = nb;
    acc = bus.push_ready;
    @(posedge clk);
  endtask

  task automatic push_wait(input logic [31:0] data, input logic [1:0] nb);
    int t;
    t = 0;
    @(negedge clk);
    bus.push_valid  = 1'b1;
    bus.push_data   = data;
    bus.push_nbytes = nb;
    while (!bus.push_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!bus.push_ready) begin
      n_errs++;
      $display("FAIL push_timeout: push_ready=%b required 1", bus.push_ready);
      bus.push_valid = 1'b0;
    end else begin
      add_exp(data, nb);
      @(posedge clk);
    end
  endtask

  task automatic stop_push();
    @(negedge clk);
    bus.push_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!(idle && !bus.out_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!(idle && !bus.out_busy)) begin
      n_errs++;
      $display("FAIL %s_idle_timeout: idle=%b busy=%b required idle=1 busy=0", tag, idle, bus.out_busy);
    end
  endtask

  task automatic compare_stream(input string tag);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errs++;
      $display("FAIL %s_len: got %0d bytes required %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errs++;
        $display("FAIL %s_byte%0d: got %02h required %02h", tag, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.out_req !== 1'b0) begin n_errs++; $display("FAIL reset_out_req: got %b required 0", bus.out_req); end
    n_checks++;
    if (bus.out_data !== 32'h0) begin n_errs++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
    n_checks++;
    if (bus.push_ready !== 1'b1) begin n_errs++; $display("FAIL reset_push_ready: got %b required 1", bus.push_ready); end
    n_checks++;
    if (fifo_count !== 5'd0) begin n_errs++; $display("FAIL reset_fifo_count: got %0d required 0", fifo_count); end
    n_checks++;
    if (idle !== 1'b1) begin n_errs++; $display("FAIL reset_idle: got %b required 1", idle); end
  endtask

  task automatic test_four_bytes();
    logic [7:0] want [4];
    want = '{8'h11, 8'h22, 8'h33, 8'h44};
    busy_len = 5;
    clear_logs();
    push_wait(32'h44332211, 2'd3);
    stop_push();
    wait_idle("four");
    n_checks++;
    if (got_q.size() != 4) begin n_errs++; $display("FAIL four_pulses: got %0d required 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== want[i]) begin n_errs++; $display("FAIL four_byte%0d: got %02h required %02h", i, got_q[i], want[i]); end
    end
    n_checks++;
    if (dbl_err != 0) begin n_errs++; $display("FAIL four_req_width: got %0d multi-cycle pulses required 0", dbl_err); end
    n_checks++;
    if (hi_err != 0) begin n_errs++; $display("FAIL four_upper_bits: got %0d nonzero required 0", hi_err); end
    n_checks++;
    if (idle !== 1'b1) begin n_errs++; $display("FAIL four_idle: got %b required 1", idle); end
  endtask

  task automatic test_single_byte();
    busy_len = 3;
    clear_logs();
    push_wait(32'h000000AB, 2'd0);
    stop_push();
    wait_idle("single");
    n_checks++;
    if (got_q.size() != 1) begin
      n_errs++;
      $display("FAIL single_pulses: got %0d required 1", got_q.size());
    end else begin
      n_checks++;
      if (req_cyc_q[0] != last_push_cyc + 3) begin
        n_errs++;
        $display("FAIL single_latency: got edge %0d required %0d", req_cyc_q[0], last_push_cyc + 3);
      end
    end
    n_checks++;
    if (bus.out_data !== 32'h000000AB) begin n_errs++; $display("FAIL single_out_data: got %h required 000000ab", bus.out_data); end
  endtask

  task automatic test_full();
    bit acc;
    int t;
    busy_stuck = 1'b1;
    clear_logs();
    push_wait(32'h000000F0, 2'd0);
    stop_push();
    t = 0;
    while (got_q.size() == 0 && t < 50) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      try_push(32'hA0 + i, 2'd0, acc);
      n_checks++;
      if (acc !== (i < 16)) begin
        n_errs++;
        $display("FAIL full_accept%0d: got %b required %b", i, acc, (i < 16));
      end
      if (i < 16) add_exp(32'hA0 + i, 2'd0);
    end
    stop_push();
    n_checks++;
    if (bus.push_ready !== 1'b0) begin n_errs++; $display("FAIL full_push_ready: got %b required 0", bus.push_ready); end
    n_checks++;
    if (fifo_count !== 5'd16) begin n_errs++; $display("FAIL full_count: got %0d required 16", fifo_count); end
    busy_stuck = 1'b0;
    wait_idle("full");
    compare_stream("full");
    n_checks++;
    if (fifo_count !== 5'd0) begin n_errs++; $display("FAIL full_drained_count: got %0d required 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    busy_len = 2;
    clear_logs();
    for (int i = 0; i < 48; i++) begin
      b = 8'(i);
      push_wait({b ^ 8'hC3, b ^ 8'h5A, b + 8'h80, b}, 2'(i % 4));
    end
    stop_push();
    wait_idle("b2b");
    compare_stream("b2b");
  endtask

  task automatic test_reset_mid();
    int t;
    int n;
    busy_stuck = 1'b1;
    clear_logs();
    push_wait(32'hDDCCBBAA, 2'd3);
    push_wait(32'h00000001, 2'd0);
    stop_push();
    t = 0;
    while (got_q.size() == 0 && t < 50) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    n_checks++;
    if (fifo_count !== 5'd1) begin n_errs++; $display("FAIL rstmid_pre_count: got %0d required 1", fifo_count); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_req !== 1'b0) begin n_errs++; $display("FAIL rstmid_out_req: got %b required 0", bus.out_req); end
    n_checks++;
    if (fifo_count !== 5'd0) begin n_errs++; $display("FAIL rstmid_count: got %0d required 0", fifo_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy_stuck = 1'b0;
    @(negedge clk);
    n_checks++;
    if (idle !== 1'b1) begin n_errs++; $display("FAIL rstmid_idle: got %b required 1", idle); end
    n = got_q.size();
    repeat (30) @(negedge clk);
    n_checks++;
    if (got_q.size() != n) begin n_errs++; $display("FAIL rstmid_no_resend: got %0d requests required %0d", got_q.size(), n); end

    // Reset while the request pulse itself is high.
    busy_len = 2;
    push_wait(32'h00000077, 2'd0);
    stop_push();
    t = 0;
    while (bus.out_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_checks++;
    if (bus.out_req !== 1'b1) begin n_errs++; $display("FAIL rstpulse_pre: got %b required 1", bus.out_req); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_req !== 1'b0) begin n_errs++; $display("FAIL rstpulse_out_req: got %b required 0", bus.out_req); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

`ifdef OUT_TX_COUNT_EN
  task automatic test_tx_count();
    apply_reset();
    n_checks++;
    if (tx_byte_count !== 32'd0) begin n_errs++; $display("FAIL txcnt_reset: got %0d required 0", tx_byte_count); end
    busy_len = 1;
    clear_logs();
    push_wait(32'h04030201, 2'd3);
    push_wait(32'h0000BEEF, 2'd1);
    stop_push();
    wait_idle("txcnt");
    n_checks++;
    if (tx_byte_count !== 32'd6) begin n_errs++; $display("FAIL txcnt_value: got %0d required 6", tx_byte_count); end
  endtask
`endif

  initial begin
    bus.push_valid  = 1'b0;
    bus.push_data   = '0;
    bus.push_nbytes = 2'd0;
    test_reset();
    test_four_bytes();
    test_single_byte();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef OUT_TX_COUNT_EN
    test_tx_count();
`endif
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/out_byte_serializer.md
Name: out_byte_serializer

Overview:
- Sits between the core's `out` instruction path and the I/O controller's output handshake (out_req / out_data / out_busy).
- Buffers up to DEPTH output requests so the core does not stall on each UART transmit.
- Each request carries a 32-bit word plus a byte count of 1–4.
- The block then issues one I/O-controller transaction per byte, LSB first, matching the controller's little-endian byte packing on the input side.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- push_valid  in  1  core requests an output
- push_data  in  `WORD_W  word to transmit
- push_nbytes  in  2  number of bytes minus 1 (0 = 1 byte … 3 = 4 bytes)
- push_ready  out  1  FIFO not full; push accepted when push_valid & push_ready
- out_req  out  1  one-cycle request pulse to the I/O controller
- out_data  out  `WORD_W  current byte in [7:0], upper bits zero
- out_busy  in  1  I/O controller busy; goes high the cycle after it samples out_req and stays high until the byte is written
- fifo_count  out  PTR_W+1  occupied entries
- idle  out  1  FIFO empty and FSM in S_IDLE

Behaviour:
- Reset values:
  - out_req=0, out_data=0, push_ready=1, fifo_count=0, idle=1.
  - FSM in S_IDLE; read/write pointers, byte shift register and remaining count all 0.
- FIFO:
  - Each entry is {nbytes[1:0], data[31:0]}.
  - Write at wr_ptr on push_valid & push_ready.
  - Pointers are PTR_W+1 bits with a wrap bit:
    - full = MSBs differ and low bits are equal.
    - empty = pointers are equal.
  - push_ready = !full, combinational from registered pointers. A push while full is ignored.
  - A simultaneous push and pop leaves count unchanged.
  - A pop in the same cycle the FIFO becomes full does not open push_ready until the next cycle.
- FSM states: S_IDLE, S_LOAD, S_ISSUE, S_GUARD, S_DRAIN.
  - S_IDLE: if !empty, pop the head entry into shreg and rem = nbytes, then go to S_LOAD.
  - S_LOAD: out_data <= {24'b0, shreg[7:0]}; out_req <= 1; go to S_ISSUE.
  - S_ISSUE: out_req <= 0 (out_req is high exactly this one cycle); go to S_GUARD.
  - S_GUARD: one cycle during which out_busy is ignored, covering the controller's one-cycle busy latency; go to S_DRAIN.
  - S_DRAIN: wait for !out_busy. Then:
    - if rem==0, go to S_IDLE;
    - else shreg >>= 8, rem -= 1, go to S_LOAD.
- out_req is registered. It never asserts while the FSM is outside S_ISSUE.
- Minimum per-byte latency: 4 cycles from S_LOAD to the next S_LOAD, plus the controller's busy time.
- out_data holds its value until the next S_LOAD.
- First-byte latency: push accepted at edge N, and the FIFO was empty with the FSM in S_IDLE:
  - pop at edge N+1;
  - out_req high during the cycle after edge N+2.
- Byte order: byte k is data[8k+7:8k], for k = 0..nbytes.
- Async reset mid-transfer:
  - out_req drops immediately; FIFO contents are discarded.
  - A byte already sampled by the controller completes on the controller side. It is not re-sent.

Optional Feature:
- Macro OUT_TX_COUNT_EN.
- When defined:
  - adds output port tx_byte_count (32 bits), reset 0;
  - increments by 1 on each S_ISSUE cycle;
  - wraps modulo 2^32.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package io_pkg holds:
  - typedef out_entry_t {logic [1:0] nbytes; logic [31:0] data;};
  - enum ser_state_t for the five states;
  - localparam OUT_BYTE_W = 8.
- `WORD_W stays in common_params.h.
- One sub-module, sync_fifo: parameterised on DEPTH and entry width, with async active-high reset and count output. It is reusable later for an input-side buffer.

Test Plan:
- Push 0x44332211 with nbytes=3; controller model holds busy for 5 cycles per byte -> out_data sequence 0x11, 0x22, 0x33, 0x44; exactly 4 single-cycle out_req pulses; idle=1 afterwards.
- Push 0x000000AB with nbytes=0 -> one out_req with out_data=0x000000AB; first out_req in the cycle after edge N+2 relative to the accepting edge N.
- With busy stuck high, push 17 entries -> push_ready=0 after the 16th; the 17th is ignored; fifo_count=16. Release busy -> all 16 entries drain in order and fifo_count returns to 0.
- Push every cycle while draining with busy=2 cycles -> no entry lost or duplicated; pointer wrap occurs (≥40 entries) and the output byte stream matches a scoreboard.
- Assert rst while in S_DRAIN with busy high -> out_req=0 and fifo_count=0 immediately; idle=1 after rst drops; no further out_req.
- With OUT_TX_COUNT_EN: push nbytes=3 then nbytes=1 -> tx_byte_count=6. Build without the macro -> elaborates with no tx_byte_count port.
